// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: player and winner codes,
// win-line masks, controller state encoding and a line helper.
package ttt_pkg;

  localparam int CELLS = 9;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;

  localparam logic [8:0] FULL_BOARD = 9'h1FF;

  // Rows, columns, then the two diagonals.
  localparam logic [7:0][8:0] WIN_LINES = {
    9'h054, 9'h111,
    9'h124, 9'h092, 9'h049,
    9'h1C0, 9'h038, 9'h007
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMMIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic logic line_done(
    input logic [8:0] board
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((board & WIN_LINES[i]) == WIN_LINES[i])
        hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational win-line detector for one player's board.
// Ports: board (9-bit cells held) -> line (any line complete).
module ttt_win_detect
  import ttt_pkg::*;
(
  input  logic [8:0] board,
  output logic       line
);

  assign line = line_done(board);

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Turn controller: accepts legal moves, alternates players,
// drives update/player/marked and reports win, draw, game over.
// Ports: clk, rst, new_game, move_valid, move_cell in;
// move_ready, update, player, marked, x_cells, o_cells,
// illegal, winner, draw, game_over out.
module ttt_turn_ctrl
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_cell,
  output logic       move_ready,
  output logic       update,
  output logic       player,
  output logic [8:0] marked,
  output logic [8:0] x_cells,
  output logic [8:0] o_cells,
  output logic       illegal,
  output logic [1:0] winner,
  output logic       draw,
  output logic       game_over
);

  state_t     state;
  logic       next_mover;
  logic [8:0] x_q;
  logic [8:0] o_q;

  logic       cell_ok;
  logic [8:0] cell_oh;
  logic       legal;
  logic       x_win;
  logic       o_win;
  logic       mover_win;

  assign x_cells = x_q;
  assign o_cells = o_q;
  assign marked  = x_q | o_q;

  // Cells 9..15 decode to no bit so they can never alias.
  assign cell_ok = move_cell < 4'd9;
  assign cell_oh = cell_ok ? (9'd1 << move_cell) : 9'd0;
  assign legal   = cell_ok && ((cell_oh & marked) == 9'd0);

  ttt_win_detect u_win_x (
    .board (x_q),
    .line  (x_win)
  );

  ttt_win_detect u_win_o (
    .board (o_q),
    .line  (o_win)
  );

  // player already holds the mover once the board is committed.
  assign mover_win = (player == PLAYER_O) ? o_win : x_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      next_mover <= FIRST_PLAYER;
      x_q        <= '0;
      o_q        <= '0;
      move_ready <= 1'b0;
      update     <= 1'b0;
      player     <= FIRST_PLAYER;
      illegal    <= 1'b0;
      winner     <= WIN_NONE;
      draw       <= 1'b0;
      game_over  <= 1'b0;
    end else if (new_game) begin
      // Any pending request is dropped; update keeps its level.
      state      <= ST_IDLE;
      next_mover <= FIRST_PLAYER;
      x_q        <= '0;
      o_q        <= '0;
      move_ready <= 1'b0;
      player     <= FIRST_PLAYER;
      illegal    <= 1'b0;
      winner     <= WIN_NONE;
      draw       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      illegal <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          move_ready <= 1'b1;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (move_valid) begin
            if (legal) begin
              if (next_mover == PLAYER_O)
                o_q <= o_q | cell_oh;
              else
                x_q <= x_q | cell_oh;
              player     <= next_mover;
              move_ready <= 1'b0;
              state      <= ST_COMMIT;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          update <= ~update;
          // Win is tested first so a 9th-move win is not a draw.
          if (mover_win) begin
            winner    <= (player == PLAYER_O) ? WIN_O : WIN_X;
            game_over <= 1'b1;
          end else if (marked == FULL_BOARD) begin
            draw      <= 1'b1;
            game_over <= 1'b1;
          end
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (game_over) begin
            state <= ST_DONE;
          end else begin
            next_mover <= ~next_mover;
            move_ready <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        ST_DONE: begin
          move_ready <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          move_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Directed bench for ttt_turn_ctrl with immediate assertions.
// Walks reset, moves, illegal requests, win, draw and new game.
module tb_ttt_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_cell;
  logic       move_ready;
  logic       update;
  logic       player;
  logic [8:0] marked;
  logic [8:0] x_cells;
  logic [8:0] o_cells;
  logic       illegal;
  logic [1:0] winner;
  logic       draw;
  logic       game_over;

  int   checks = 0;
  int   errors = 0;
  logic exp_upd;

  always #5 clk = ~clk;

  ttt_turn_ctrl #(.FIRST_PLAYER(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_cell  (move_cell),
    .move_ready (move_ready),
    .update     (update),
    .player     (player),
    .marked     (marked),
    .x_cells    (x_cells),
    .o_cells    (o_cells),
    .illegal    (illegal),
    .winner     (winner),
    .draw       (draw),
    .game_over  (game_over)
  );

  task automatic chk(
    input string      tag,
    input logic [8:0] obs,
    input logic [8:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (move_ready) break;
      step();
    end
    chk("ready_wait", 9'(move_ready), 9'h1);
  endtask

  task automatic req(input logic [3:0] c);
    wait_ready();
    move_valid = 1'b1;
    move_cell  = c;
    step();
    move_valid = 1'b0;
    move_cell  = 4'd0;
  endtask

  // Leaves the bench at N+3 of the accepted move.
  task automatic play(input logic [3:0] c, input logic p);
    req(c);
    chk("player", 9'(player), 9'(p));
    chk("ready_drop", 9'(move_ready), 9'h0);
    step();
    exp_upd = ~exp_upd;
    chk("update", 9'(update), 9'(exp_upd));
    step();
  endtask

  task automatic restart();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    chk("ng_marked", marked, 9'h000);
    chk("ng_ready", 9'(move_ready), 9'h0);
    step();
    chk("ng_wait", 9'(move_ready), 9'h1);
  endtask

  logic [3:0] seq [9];

  initial begin
    seq = '{4'd4, 4'd0, 4'd8, 4'd2, 4'd1,
            4'd7, 4'd6, 4'd3, 4'd5};
    rst        = 1'b1;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_cell  = 4'd0;
    exp_upd    = 1'b0;
    step();
    step();
    chk("rst_ready", 9'(move_ready), 9'h0);
    chk("rst_update", 9'(update), 9'h0);
    chk("rst_illegal", 9'(illegal), 9'h0);
    chk("rst_marked", marked, 9'h000);
    chk("rst_x", x_cells, 9'h000);
    chk("rst_o", o_cells, 9'h000);
    chk("rst_winner", 9'(winner), 9'h0);
    chk("rst_draw", 9'(draw), 9'h0);
    chk("rst_over", 9'(game_over), 9'h0);
    chk("rst_player", 9'(player), 9'h0);
    rst = 1'b0;
    step();
    chk("idle_to_wait", 9'(move_ready), 9'h1);

    // X at 4, O at 0.
    play(4'd4, 1'b0);
    chk("t1_marked1", marked, 9'h010);
    chk("t1_x1", x_cells, 9'h010);
    chk("t1_ready", 9'(move_ready), 9'h1);
    play(4'd0, 1'b1);
    chk("t1_marked2", marked, 9'h011);
    chk("t1_o2", o_cells, 9'h001);

    // O requests an occupied cell.
    restart();
    play(4'd4, 1'b0);
    req(4'd4);
    chk("occ_illegal", 9'(illegal), 9'h1);
    chk("occ_marked", marked, 9'h010);
    chk("occ_ready", 9'(move_ready), 9'h1);
    chk("occ_update", 9'(update), 9'(exp_upd));
    step();
    chk("occ_pulse_end", 9'(illegal), 9'h0);
    play(4'd0, 1'b1);
    chk("occ_o_next", o_cells, 9'h001);

    // Out-of-range cell.
    req(4'd12);
    chk("oor_illegal", 9'(illegal), 9'h1);
    chk("oor_marked", marked, 9'h011);
    step();
    chk("oor_pulse_end", 9'(illegal), 9'h0);

    // X wins on the top row.
    restart();
    play(4'd0, 1'b0);
    play(4'd3, 1'b1);
    play(4'd1, 1'b0);
    play(4'd4, 1'b1);
    req(4'd2);
    chk("win_x_n1", x_cells, 9'h007);
    chk("win_over_n1", 9'(game_over), 9'h0);
    step();
    exp_upd = ~exp_upd;
    chk("win_update", 9'(update), 9'(exp_upd));
    chk("win_winner", 9'(winner), 9'h1);
    chk("win_over", 9'(game_over), 9'h1);
    chk("win_draw", 9'(draw), 9'h0);
    step();
    chk("done_ready", 9'(move_ready), 9'h0);
    move_valid = 1'b1;
    move_cell  = 4'd5;
    step();
    step();
    chk("done_illegal", 9'(illegal), 9'h0);
    chk("done_marked", marked, 9'h01F);
    chk("done_ready2", 9'(move_ready), 9'h0);
    chk("done_update", 9'(update), 9'(exp_upd));
    move_valid = 1'b0;

    // Full board without a line.
    restart();
    for (int i = 0; i < 9; i++)
      play(seq[i], 1'((i % 2) != 0));
    chk("draw_flag", 9'(draw), 9'h1);
    chk("draw_winner", 9'(winner), 9'h0);
    chk("draw_over", 9'(game_over), 9'h1);
    chk("draw_marked", marked, 9'h1FF);
    chk("draw_ready", 9'(move_ready), 9'h0);

    // new_game collides with an accepted move.
    restart();
    play(4'd4, 1'b0);
    play(4'd0, 1'b1);
    play(4'd8, 1'b0);
    wait_ready();
    move_valid = 1'b1;
    move_cell  = 4'd1;
    new_game   = 1'b1;
    step();
    move_valid = 1'b0;
    new_game   = 1'b0;
    chk("coll_marked", marked, 9'h000);
    chk("coll_player", 9'(player), 9'h0);
    chk("coll_update", 9'(update), 9'(exp_upd));
    chk("coll_illegal", 9'(illegal), 9'h0);
    chk("coll_idle", 9'(move_ready), 9'h0);
    step();
    chk("coll_wait", 9'(move_ready), 9'h1);
    play(4'd1, 1'b0);
    chk("coll_x_first", x_cells, 9'h002);

    // Asynchronous reset in the middle of a move.
    req(4'd4);
    chk("mid_marked", marked, 9'h012);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_marked", marked, 9'h000);
    chk("mid_rst_update", 9'(update), 9'h0);
    chk("mid_rst_ready", 9'(move_ready), 9'h0);
    chk("mid_rst_player", 9'(player), 9'h0);
    step();
    rst     = 1'b0;
    exp_upd = 1'b0;
    step();
    step();
    chk("mid_rst_wait", 9'(move_ready), 9'h1);
    chk("mid_rst_update2", 9'(update), 9'(exp_upd));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
